// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and slave FSM state codes for the memory slave.
package ahb_pkg;

  // HTRANS encodings
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  // HSIZE encodings supported by a 32-bit slave
  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  // HRESP encodings
  localparam logic RESP_OKAY  = 1'b0;
  localparam logic RESP_ERROR = 1'b1;

  // Slave FSM state enumeration (plain constants for legacy tools)
  typedef logic [2:0] slv_state_t;
  localparam slv_state_t ST_IDLE = 3'd0;
  localparam slv_state_t ST_WAIT = 3'd1;
  localparam slv_state_t ST_DONE = 3'd2;
  localparam slv_state_t ST_ERR1 = 3'd3;
  localparam slv_state_t ST_ERR2 = 3'd4;

endpackage

// File: rtl/ahb_slave_lane_mask.sv
// Little-endian byte-enable decode for one 32-bit word lane set.
// Produces the 4-bit lane mask for a transfer and flags sizes or
// alignments that a 32-bit slave cannot serve.
module ahb_slave_lane_mask
  import ahb_pkg::*;
(
  input  logic [1:0] offset_lo,
  input  logic [2:0] size,
  output logic [3:0] byte_en,
  output logic       align_err
);

  // Decode size and low address bits into lanes and an alignment fault
  always_comb begin
    byte_en   = 4'b0000;
    align_err = 1'b0;
    case (size)
      HSIZE_BYTE: begin
        byte_en = 4'b0001 << offset_lo;
      end
      HSIZE_HALF: begin
        byte_en   = offset_lo[1] ? 4'b1100 : 4'b0011;
        align_err = offset_lo[0];
      end
      HSIZE_WORD: begin
        byte_en   = 4'b1111;
        align_err = (offset_lo != 2'b00);
      end
      default: begin
        // Anything wider than a word cannot be served on 32-bit lanes
        align_err = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB-Lite memory-backed slave with configurable wait states and the
// two-cycle ERROR response for illegal accesses.
//
// Optional feature macro: AHB_SLAVE_HPROT_EN
//   defined   -> adds ahb_prot_in; user-mode (prot[1]=0) writes get ERROR
//   undefined -> no protection port, every access treated as privileged
//
// Handshake: an address phase is taken on a rising edge where
// ahb_sel_in & ahb_ready_in & (HTRANS is NONSEQ or SEQ) while the FSM is
// able to take one (IDLE, DONE or ERR2). The data phase ends on the first
// rising edge where ahb_readyout_out is 1; ahb_resp_out and ahb_rdata_out
// are meaningful only in that cycle (and resp also in the ERR1 cycle).
module ahb_slave_mem
  import ahb_pkg::*;
#(
  parameter int AHB_ADDR_WIDTH    = 32,
  parameter int AHB_DATA_WIDTH    = 32,
  parameter int SLAVE_SPACE_WIDTH = 10,
  parameter int MEM_DEPTH         = 128,
  parameter int WAIT_STATES       = 1
) (
  input  logic                      ahb_clk_in,
  input  logic                      ahb_rstn_in,
  input  logic                      ahb_sel_in,
  input  logic [AHB_ADDR_WIDTH-1:0] ahb_addr_in,
  input  logic [1:0]                ahb_trans_in,
  input  logic                      ahb_write_in,
  input  logic [2:0]                ahb_size_in,
  input  logic [AHB_DATA_WIDTH-1:0] ahb_wdata_in,
  input  logic                      ahb_ready_in,
`ifdef AHB_SLAVE_HPROT_EN
  input  logic [3:0]                ahb_prot_in,
`endif
  output logic [AHB_DATA_WIDTH-1:0] ahb_rdata_out,
  output logic                      ahb_readyout_out,
  output logic                      ahb_resp_out
);

  localparam int         IDX_W     = $clog2(MEM_DEPTH);
  localparam int         MEM_BYTES = MEM_DEPTH * 4;
  localparam logic [3:0] WAIT_LOAD = 4'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

  // Observable FSM state and latched address-phase information
  slv_state_t       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0] word_idx_q;
  logic             write_q;
  logic [3:0]       be_q;

  logic [AHB_DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic [SLAVE_SPACE_WIDTH-1:0] addr_offset;
  logic                         active_trans;
  logic                         can_take;
  logic                         take;
  logic [3:0]                   lane_be;
  logic                         lane_align_err;
  logic                         range_err;
  logic                         prot_err;
  logic                         illegal;
  slv_state_t                   take_target;
  logic                         unused_addr;

  assign addr_offset  = ahb_addr_in[SLAVE_SPACE_WIDTH-1:0];
  assign active_trans = (ahb_trans_in == HTRANS_NONSEQ) || (ahb_trans_in == HTRANS_SEQ);
  assign can_take     = (state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR2);
  assign take         = ahb_sel_in & ahb_ready_in & active_trans & can_take;

  // Bits above the local window are decoded upstream
  assign unused_addr  = ^ahb_addr_in;

  ahb_slave_lane_mask u_lane_mask (
    .offset_lo (addr_offset[1:0]),
    .size      (ahb_size_in),
    .byte_en   (lane_be),
    .align_err (lane_align_err)
  );

  assign range_err = (32'(addr_offset) >= 32'(MEM_BYTES));

`ifdef AHB_SLAVE_HPROT_EN
  logic unused_prot;
  assign unused_prot = ^{ahb_prot_in[3:2], ahb_prot_in[0]};
  // User-mode writes are rejected; reads ignore protection
  assign prot_err    = ahb_write_in & ~ahb_prot_in[1];
`else
  assign prot_err    = 1'b0;
`endif

  assign illegal     = range_err | lane_align_err | prot_err;
  assign take_target = illegal ? ST_ERR1 : ((WAIT_STATES > 0) ? ST_WAIT : ST_DONE);

  // Next-state and wait counter; completion states can chain a new transfer
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR2: begin
        if (take) begin
          state_d = take_target;
          if (take_target == ST_WAIT) begin
            cnt_d = WAIT_LOAD;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ERR1: begin
        state_d = ST_ERR2;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // FSM state and wait counter registers
  always_ff @(posedge ahb_clk_in or negedge ahb_rstn_in) begin
    if (!ahb_rstn_in) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Capture the address phase that is being taken
  always_ff @(posedge ahb_clk_in or negedge ahb_rstn_in) begin
    if (!ahb_rstn_in) begin
      word_idx_q <= '0;
      write_q    <= 1'b0;
      be_q       <= 4'b0000;
    end else if (take) begin
      word_idx_q <= addr_offset[IDX_W+1:2];
      write_q    <= ahb_write_in;
      be_q       <= lane_be;
    end
  end

  // Commit write lanes at the end of the DONE cycle; storage is not reset
  always_ff @(posedge ahb_clk_in) begin
    if ((state_q == ST_DONE) && write_q) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) begin
          mem[word_idx_q][8*i +: 8] <= ahb_wdata_in[8*i +: 8];
        end
      end
    end
  end

  // Response outputs decoded from the state; read data only in a read DONE
  always_comb begin
    ahb_readyout_out = 1'b1;
    ahb_resp_out     = RESP_OKAY;
    ahb_rdata_out    = '0;
    case (state_q)
      ST_WAIT: begin
        ahb_readyout_out = 1'b0;
      end
      ST_DONE: begin
        if (!write_q) begin
          ahb_rdata_out = mem[word_idx_q];
        end
      end
      ST_ERR1: begin
        ahb_readyout_out = 1'b0;
        ahb_resp_out     = RESP_ERROR;
      end
      ST_ERR2: begin
        ahb_resp_out = RESP_ERROR;
      end
      default: begin
        ahb_readyout_out = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Bench for ahb_slave_mem: one instance with one wait state, one with none.
// Drivers push expected data-phase results; one monitor pops and compares.
module tb_ahb_slave_mem;
  import ahb_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // ---------------- bus signals, index 0: WAIT_STATES=1, 1: WAIT_STATES=0
  logic        sel       [2];
  logic [31:0] addr      [2];
  logic [1:0]  trans     [2];
  logic        write     [2];
  logic [2:0]  size      [2];
  logic [31:0] wdata     [2];
  logic        ready_low [2];
  logic        ready_in  [2];
  logic [31:0] rdata     [2];
  logic        readyout  [2];
  logic        resp      [2];
`ifdef AHB_SLAVE_HPROT_EN
  logic [3:0]  prot      [2];
  logic [3:0]  cur_prot = 4'b0011;
`endif

  // Single-slave bus: HREADY is this slave's HREADYOUT unless forced low
  assign ready_in[0] = readyout[0] & ~ready_low[0];
  assign ready_in[1] = readyout[1] & ~ready_low[1];

  ahb_slave_mem #(.WAIT_STATES(1)) dut_ws1 (
    .ahb_clk_in       (clk),
    .ahb_rstn_in      (rst_n),
    .ahb_sel_in       (sel[0]),
    .ahb_addr_in      (addr[0]),
    .ahb_trans_in     (trans[0]),
    .ahb_write_in     (write[0]),
    .ahb_size_in      (size[0]),
    .ahb_wdata_in     (wdata[0]),
    .ahb_ready_in     (ready_in[0]),
`ifdef AHB_SLAVE_HPROT_EN
    .ahb_prot_in      (prot[0]),
`endif
    .ahb_rdata_out    (rdata[0]),
    .ahb_readyout_out (readyout[0]),
    .ahb_resp_out     (resp[0])
  );

  ahb_slave_mem #(.WAIT_STATES(0)) dut_ws0 (
    .ahb_clk_in       (clk),
    .ahb_rstn_in      (rst_n),
    .ahb_sel_in       (sel[1]),
    .ahb_addr_in      (addr[1]),
    .ahb_trans_in     (trans[1]),
    .ahb_write_in     (write[1]),
    .ahb_size_in      (size[1]),
    .ahb_wdata_in     (wdata[1]),
    .ahb_ready_in     (ready_in[1]),
`ifdef AHB_SLAVE_HPROT_EN
    .ahb_prot_in      (prot[1]),
`endif
    .ahb_rdata_out    (rdata[1]),
    .ahb_readyout_out (readyout[1]),
    .ahb_resp_out     (resp[1])
  );

  // ---------------- scoreboard state ----------------
  // Entry: {is_err, is_read, low_cycles[3:0], rdata[31:0]}
  logic [37:0] exp_q0[$];
  logic [37:0] exp_q1[$];
  int          checks   = 0;
  int          errors   = 0;
  logic        end_req  = 1'b0;
  logic        end_done = 1'b0;

  // ---------------- driver tasks ----------------
  task automatic wait_ready(input int d);
    int n;
    n = 0;
    @(negedge clk);
    while (!ready_in[d]) begin
      n++;
      if (n > 40) begin
        $display("FAIL ready_timeout dut%0d: ready still 0 after %0d cycles, required 1", d, n);
        $fatal(1, "bus stalled");
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int d, input logic [31:0] a, input logic w,
                      input logic [2:0] sz, input logic [31:0] wd,
                      input logic err, input logic [31:0] exp_rd, input int lows);
    logic [37:0] e;
    e = {err, ~w, 4'(lows), exp_rd};
    if (d == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
    sel[d]   = 1'b1;
    addr[d]  = a;
    trans[d] = HTRANS_NONSEQ;
    write[d] = w;
    size[d]  = sz;
`ifdef AHB_SLAVE_HPROT_EN
    prot[d]  = cur_prot;
`endif
    wait_ready(d);
    wdata[d] = wd;
  endtask

  task automatic idle_bus(input int d);
    sel[d]   = 1'b0;
    trans[d] = HTRANS_IDLE;
    write[d] = 1'b0;
    addr[d]  = '0;
    wait_ready(d);
    wdata[d] = '0;
  endtask

  task automatic hold_nop(input int d, input logic [1:0] tr, input logic rdy_lo,
                          input logic [31:0] a, input int cycles);
    sel[d]       = 1'b1;
    trans[d]     = tr;
    addr[d]      = a;
    write[d]     = 1'b1;
    size[d]      = HSIZE_WORD;
    wdata[d]     = 32'h0BAD0BAD;
    ready_low[d] = rdy_lo;
    repeat (cycles) @(posedge clk);
    #1;
    sel[d]       = 1'b0;
    trans[d]     = HTRANS_IDLE;
    write[d]     = 1'b0;
    wdata[d]     = '0;
    ready_low[d] = 1'b0;
  endtask

  // ---------------- monitor ----------------
  logic in_data  [2] = '{1'b0, 1'b0};
  int   low_cnt  [2] = '{0, 0};
  logic low_any  [2] = '{1'b0, 1'b0};
  logic low_all  [2] = '{1'b1, 1'b1};

  // Compare every finished data phase against the queue; idle cycles must show reset outputs
  always @(negedge clk) begin
    logic [37:0] e;
    logic        e_err;
    logic        low_bad;
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) in_data[d] = 1'b0;
      if (in_data[d]) begin
        if (!readyout[d]) begin
          low_cnt[d]++;
          low_any[d] = low_any[d] | resp[d];
          low_all[d] = low_all[d] & resp[d];
        end else begin
          checks++;
          if ((d == 0 && exp_q0.size() == 0) || (d == 1 && exp_q1.size() == 0)) begin
            errors++;
            $display("FAIL unexpected_completion dut%0d: got a completed transfer, required none", d);
          end else begin
            if (d == 0) e = exp_q0.pop_front();
            else        e = exp_q1.pop_front();
            e_err = e[37];
            if (low_cnt[d] != int'(e[35:32])) begin
              errors++;
              $display("FAIL wait_cycles dut%0d: got %0d, required %0d", d, low_cnt[d], e[35:32]);
            end
            checks++;
            if (resp[d] !== e_err) begin
              errors++;
              $display("FAIL resp dut%0d: got %b, required %b", d, resp[d], e_err);
            end
            checks++;
            if (rdata[d] !== e[31:0]) begin
              errors++;
              $display("FAIL rdata dut%0d: got %h, required %h", d, rdata[d], e[31:0]);
            end
            checks++;
            low_bad = e_err ? (low_cnt[d] == 0 || !low_all[d]) : low_any[d];
            if (low_bad) begin
              errors++;
              $display("FAIL wait_resp dut%0d: got resp any=%b all=%b in low cycles, required %b",
                       d, low_any[d], low_all[d], e_err);
            end
          end
          in_data[d] = 1'b0;
        end
      end else begin
        checks++;
        if (readyout[d] !== 1'b1 || resp[d] !== 1'b0 || rdata[d] !== 32'h0) begin
          errors++;
          $display("FAIL idle_outputs dut%0d: got readyout=%b resp=%b rdata=%h, required 1 0 00000000",
                   d, readyout[d], resp[d], rdata[d]);
        end
      end
      if (rst_n && sel[d] && ready_in[d] && trans[d][1]) begin
        in_data[d] = 1'b1;
        low_cnt[d] = 0;
        low_any[d] = 1'b0;
        low_all[d] = 1'b1;
      end
    end
    if (end_req && !end_done) begin
      checks++;
      if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
        errors++;
        $display("FAIL pending_expect: got %0d/%0d entries left, required 0/0",
                 exp_q0.size(), exp_q1.size());
      end
      end_done = 1'b1;
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    for (int d = 0; d < 2; d++) begin
      sel[d] = 1'b0; addr[d] = '0; trans[d] = HTRANS_IDLE; write[d] = 1'b0;
      size[d] = HSIZE_WORD; wdata[d] = '0; ready_low[d] = 1'b0;
`ifdef AHB_SLAVE_HPROT_EN
      prot[d] = 4'b0011;
`endif
    end
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Word write then read, one wait state each
    send(0, 32'h10, 1'b1, HSIZE_WORD, 32'hDEADBEEF, 1'b0, 32'h0,        1);
    send(0, 32'h10, 1'b0, HSIZE_WORD, 32'h0,        1'b0, 32'hDEADBEEF, 1);
    idle_bus(0);

    // Byte and halfword lanes; unused write lanes carry junk
    send(0, 32'h10, 1'b1, HSIZE_WORD, 32'h11223344, 1'b0, 32'h0,        1);
    send(0, 32'h13, 1'b1, HSIZE_BYTE, 32'hAA5A5A5A, 1'b0, 32'h0,        1);
    send(0, 32'h10, 1'b0, HSIZE_WORD, 32'h0,        1'b0, 32'hAA223344, 1);
    send(0, 32'h12, 1'b1, HSIZE_HALF, 32'h5566A5A5, 1'b0, 32'h0,        1);
    send(0, 32'h10, 1'b0, HSIZE_WORD, 32'h0,        1'b0, 32'h55663344, 1);
    send(0, 32'h14, 1'b1, HSIZE_WORD, 32'h00000000, 1'b0, 32'h0,        1);
    send(0, 32'h15, 1'b1, HSIZE_BYTE, 32'hFFFF77FF, 1'b0, 32'h0,        1);
    send(0, 32'h14, 1'b0, HSIZE_WORD, 32'h0,        1'b0, 32'h00007700, 1);
    send(0, 32'h14, 1'b1, HSIZE_HALF, 32'hFFFF9988, 1'b0, 32'h0,        1);
    send(0, 32'h14, 1'b0, HSIZE_WORD, 32'h0,        1'b0, 32'h00009988, 1);
    send(0, 32'h1FC, 1'b1, HSIZE_WORD, 32'hCAFEF00D, 1'b0, 32'h0,       1);
    send(0, 32'h1FC, 1'b0, HSIZE_WORD, 32'h0,        1'b0, 32'hCAFEF00D, 1);
    idle_bus(0);

    // Illegal accesses: range, alignment, oversize
    send(0, 32'h202, 1'b0, HSIZE_WORD, 32'h0,      1'b1, 32'h0, 1);
    send(0, 32'h01,  1'b0, HSIZE_HALF, 32'h0,      1'b1, 32'h0, 1);
    send(0, 32'h200, 1'b1, HSIZE_WORD, 32'h0,      1'b1, 32'h0, 1);
    send(0, 32'h11,  1'b1, HSIZE_WORD, 32'h0,      1'b1, 32'h0, 1);
    send(0, 32'h10,  1'b1, 3'd3,       32'h0,      1'b1, 32'h0, 1);
    send(0, 32'h13,  1'b1, HSIZE_HALF, 32'h0,      1'b1, 32'h0, 1);
    send(0, 32'h10,  1'b0, HSIZE_WORD, 32'h0,      1'b0, 32'h55663344, 1);
    send(0, 32'h1FC, 1'b0, HSIZE_WORD, 32'h0,      1'b0, 32'hCAFEF00D, 1);
    idle_bus(0);

    // IDLE/BUSY while selected, NONSEQ with HREADY low: nothing happens
    hold_nop(0, HTRANS_IDLE,   1'b0, 32'h10, 2);
    hold_nop(0, HTRANS_BUSY,   1'b0, 32'h10, 2);
    hold_nop(0, HTRANS_NONSEQ, 1'b1, 32'h10, 3);
    send(0, 32'h10, 1'b0, HSIZE_WORD, 32'h0, 1'b0, 32'h55663344, 1);
    idle_bus(0);

`ifdef AHB_SLAVE_HPROT_EN
    // Protection: user writes rejected, user reads allowed
    send(0, 32'h40, 1'b1, HSIZE_WORD, 32'h11111111, 1'b0, 32'h0, 1);
    cur_prot = 4'b0001;
    send(0, 32'h40, 1'b1, HSIZE_WORD, 32'h22222222, 1'b1, 32'h0, 1);
    send(0, 32'h40, 1'b0, HSIZE_WORD, 32'h0,        1'b0, 32'h11111111, 1);
    cur_prot = 4'b0011;
    send(0, 32'h40, 1'b1, HSIZE_WORD, 32'h33333333, 1'b0, 32'h0, 1);
    send(0, 32'h40, 1'b0, HSIZE_WORD, 32'h0,        1'b0, 32'h33333333, 1);
    idle_bus(0);
`endif

    // Reset in the WAIT cycle of a write aborts it
    send(0, 32'h30, 1'b1, HSIZE_WORD, 32'h0, 1'b0, 32'h0, 1);
    idle_bus(0);
    sel[0]   = 1'b1;
    addr[0]  = 32'h30;
    trans[0] = HTRANS_NONSEQ;
    write[0] = 1'b1;
    size[0]  = HSIZE_WORD;
    wait_ready(0);
    wdata[0] = 32'hFFFFFFFF;
    sel[0]   = 1'b0;
    trans[0] = HTRANS_IDLE;
    rst_n    = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wdata[0] = '0;
    @(posedge clk);
    #1;
    send(0, 32'h30, 1'b0, HSIZE_WORD, 32'h0, 1'b0, 32'h0, 1);
    idle_bus(0);

    // Zero wait states: back-to-back write then read, no bubble
    send(1, 32'h20, 1'b1, HSIZE_WORD, 32'h12345678, 1'b0, 32'h0,        0);
    send(1, 32'h20, 1'b0, HSIZE_WORD, 32'h0,        1'b0, 32'h12345678, 0);
    send(1, 32'h21, 1'b1, HSIZE_BYTE, 32'hFFFFABFF, 1'b0, 32'h0,        0);
    send(1, 32'h20, 1'b0, HSIZE_WORD, 32'h0,        1'b0, 32'h1234AB78, 0);
    send(1, 32'h23, 1'b1, HSIZE_HALF, 32'h0,        1'b1, 32'h0,        1);
    send(1, 32'h20, 1'b0, HSIZE_WORD, 32'h0,        1'b0, 32'h1234AB78, 0);
    idle_bus(1);

    repeat (3) @(posedge clk);
    end_req = 1'b1;
    for (int i = 0; i < 10 && !end_done; i++) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
